sm_prog_loader: RTL and testbench

- Byte-stream program loader directly upstream of sm_top.
- Takes bytes from a UART receiver, assembles 32-bit little-endian instruction words and writes them into instruction memory from address 0.
- Holds the CPU in reset while a load is in progress, then releases it.
- Lets a board or bench replace the program without resynthesis.

---
 rtl/sm_prog_loader_pkg.sv | 28 ++
 rtl/sm_loader_word_asm.sv | 45 ++++
 rtl/sm_prog_loader.sv | 175 +++++++++++++++++
 tb/tb_sm_prog_loader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_prog_loader_pkg.sv
// Shared definitions for the byte-stream program loader: FSM states,
// sticky error codes and a small state-classification helper.
package sm_prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN0 = 3'd1,
    LEN1 = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4,
    ERR  = 3'd5
  } loaderState_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_CSUM    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } loaderErr_t;

  localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

  // True for the states that belong to an open frame (busy, timeout armed)
  function automatic logic inFrame(input loaderState_t s);
    return (s == LEN0) || (s == LEN1) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/sm_loader_word_asm.sv
// Little-endian word assembler: collects four bytes into a 32-bit word
// and emits a registered one-cycle word-valid pulse with the finished word.
module sm_loader_word_asm
  import sm_prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byteValid,
  input  logic [7:0]  byteIn,
  output logic        lastByte,
  output logic        wordValid,
  output logic [31:0] wordData
);

  logic [1:0]  byteIdx;
  logic [23:0] shiftBuf;

  // The incoming byte completes a word when it lands at index 3
  assign lastByte = (byteIdx == 2'd3);

  // Shift bytes in from the top so the first byte ends up in bits [7:0]
  always_ff @(posedge clk) begin
    if (rst) begin
      byteIdx   <= 2'd0;
      shiftBuf  <= 24'd0;
      wordValid <= 1'b0;
      wordData  <= 32'd0;
    end else begin
      wordValid <= 1'b0;
      if (clear) begin
        byteIdx <= 2'd0;
      end else if (byteValid) begin
        byteIdx <= byteIdx + 2'd1;
        if (lastByte) begin
          wordValid <= 1'b1;
          wordData  <= {byteIn, shiftBuf};
        end else begin
          shiftBuf <= {byteIn, shiftBuf[23:8]};
        end
      end
    end
  end

endmodule

// File: rtl/sm_prog_loader.sv
// Program loader: parses MAGIC/LEN/data/CSUM frames from a UART byte stream,
// writes assembled words into instruction memory and holds the CPU in reset
// while a frame is open or after a failed load.
module sm_prog_loader
  import sm_prog_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH = 6,
  parameter logic [7:0] MAGIC      = DEFAULT_MAGIC,
  parameter int         TIMEOUT    = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            err
);

  localparam int              CNT_W        = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [16:0]     MAX_WORDS    = 17'(1 << ADDR_WIDTH);

  loaderState_t          state, stateNext;
  loaderErr_t            errQ, errNext;
  logic [15:0]           len, lenNext;
  logic [7:0]            xorAcc, xorAccNext;
  logic [ADDR_WIDTH-1:0] wordAddr, wordAddrNext;
  logic [ADDR_WIDTH-1:0] imemAddrQ, imemAddrNext;
  logic [CNT_W-1:0]      idleCnt, idleCntNext;
  logic                  busyQ, doneQ, doneNext, cpuRstNQ;
  logic                  frameStart, byteLoad, lastByte;
  logic [15:0]           lenFull;
  logic                  lastWord;

  assign lenFull  = {rx_data, len[7:0]};
  assign lastWord = (16'(wordAddr) == (len - 16'd1));

  sm_loader_word_asm wordAsm (
    .clk      (clk),
    .rst      (rst),
    .clear    (frameStart),
    .byteValid(byteLoad),
    .byteIn   (rx_data),
    .lastByte (lastByte),
    .wordValid(imem_we),
    .wordData (imem_wdata)
  );

  assign imem_addr = imemAddrQ;
  assign cpu_rst_n = cpuRstNQ;
  assign busy      = busyQ;
  assign done      = doneQ;
  assign err       = errQ;

  // Next-state logic: frame parsing, length check, checksum and idle timeout
  always_comb begin
    stateNext    = state;
    errNext      = errQ;
    lenNext      = len;
    xorAccNext   = xorAcc;
    wordAddrNext = wordAddr;
    imemAddrNext = imemAddrQ;
    idleCntNext  = idleCnt;
    doneNext     = 1'b0;
    frameStart   = 1'b0;
    byteLoad     = 1'b0;

    case (state)
      IDLE, ERR: begin
        if (rx_valid && (rx_data == MAGIC)) begin
          stateNext    = LEN0;
          errNext      = ERR_NONE;
          lenNext      = 16'd0;
          xorAccNext   = 8'd0;
          wordAddrNext = '0;
          idleCntNext  = '0;
          frameStart   = 1'b1;
        end
      end
      LEN0: begin
        if (rx_valid) begin
          lenNext[7:0] = rx_data;
          idleCntNext  = '0;
          stateNext    = LEN1;
        end
      end
      LEN1: begin
        if (rx_valid) begin
          lenNext[15:8] = rx_data;
          idleCntNext   = '0;
          if ({1'b0, lenFull} > MAX_WORDS) begin
            stateNext = ERR;
            errNext   = ERR_LEN;
          end else if (lenFull == 16'd0) begin
            stateNext = CSUM;
          end else begin
            stateNext = DATA;
          end
        end
      end
      DATA: begin
        if (rx_valid) begin
          byteLoad    = 1'b1;
          xorAccNext  = xorAcc ^ rx_data;
          idleCntNext = '0;
          if (lastByte) begin
            imemAddrNext = wordAddr;
            wordAddrNext = wordAddr + ADDR_WIDTH'(1);
            if (lastWord) begin
              stateNext = CSUM;
            end
          end
        end
      end
      CSUM: begin
        if (rx_valid) begin
          idleCntNext = '0;
          if (rx_data == xorAcc) begin
            stateNext = IDLE;
            doneNext  = 1'b1;
          end else begin
            stateNext = ERR;
            errNext   = ERR_CSUM;
          end
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    if (inFrame(state) && !rx_valid) begin
      if (idleCnt == TIMEOUT_LAST) begin
        stateNext   = ERR;
        errNext     = ERR_TIMEOUT;
        idleCntNext = '0;
      end else begin
        idleCntNext = idleCnt + CNT_W'(1);
      end
    end
  end

  // State and output registers; busy and cpu_rst_n follow the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      errQ      <= ERR_NONE;
      len       <= 16'd0;
      xorAcc    <= 8'd0;
      wordAddr  <= '0;
      imemAddrQ <= '0;
      idleCnt   <= '0;
      busyQ     <= 1'b0;
      doneQ     <= 1'b0;
      cpuRstNQ  <= 1'b1;
    end else begin
      state     <= stateNext;
      errQ      <= errNext;
      len       <= lenNext;
      xorAcc    <= xorAccNext;
      wordAddr  <= wordAddrNext;
      imemAddrQ <= imemAddrNext;
      idleCnt   <= idleCntNext;
      busyQ     <= inFrame(stateNext);
      doneQ     <= doneNext;
      cpuRstNQ  <= (stateNext == IDLE);
    end
  end

endmodule

// File: tb/tb_sm_prog_loader.sv
// Self-checking bench for sm_prog_loader: directed frames plus randomized
// frames, each checked against a frame-level expectation built by the bench.
module tb_sm_prog_loader;

  localparam int         ADDR_WIDTH = 6;
  localparam int         TIMEOUT    = 50;
  localparam logic [7:0] MAGIC      = 8'hA5;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  rx_valid = 1'b0;
  logic [7:0]            rx_data = 8'd0;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  cpu_rst_n;
  logic                  busy;
  logic                  done;
  logic [1:0]            err;

  int checks = 0;
  int failures = 0;

  logic [31:0] obsAddr[$];
  logic [31:0] obsData[$];
  int          doneCount = 0;
  int          overlapCount = 0;
  logic [31:0] wordsToSend[$];

  sm_prog_loader #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .MAGIC     (MAGIC),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_rst_n (cpu_rst_n),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Record memory writes and done pulses away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_we) begin
        obsAddr.push_back(32'(imem_addr));
        obsData.push_back(imem_wdata);
      end
      if (done) doneCount++;
      if (done && imem_we) overlapCount++;
    end
  end

  // Safety net so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic clearObserved();
    obsAddr.delete();
    obsData.delete();
    doneCount = 0;
  endtask

  task automatic checkWrites(input string tag, input logic [31:0] expData[$]);
    checkOutput({tag, "_nwrites"}, 32'(obsData.size()), 32'(expData.size()));
    for (int i = 0; i < expData.size(); i++) begin
      if (i < obsData.size()) begin
        checkOutput({tag, "_addr"}, obsAddr[i], 32'(i));
        checkOutput({tag, "_data"}, obsData[i], expData[i]);
      end
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_we"},    32'(imem_we),    32'd0);
    checkOutput({tag, "_addr"},  32'(imem_addr),  32'd0);
    checkOutput({tag, "_wdata"}, imem_wdata,      32'd0);
    checkOutput({tag, "_cpurn"}, 32'(cpu_rst_n),  32'd1);
    checkOutput({tag, "_busy"},  32'(busy),       32'd0);
    checkOutput({tag, "_done"},  32'(done),       32'd0);
    checkOutput({tag, "_err"},   32'(err),        32'd0);
  endtask

  // Sends one frame carrying wordsToSend; the checksum is the XOR of data bytes
  task automatic runFrame(input string tag, input bit badCsum, input int maxGap);
    logic [7:0]  csum;
    logic [7:0]  b;
    logic [15:0] n;
    logic [31:0] w;
    csum = 8'd0;
    n = 16'(wordsToSend.size());
    clearObserved();
    applyStimulus(MAGIC);
    checkOutput({tag, "_busy_open"},  32'(busy),      32'd1);
    checkOutput({tag, "_cpurn_open"}, 32'(cpu_rst_n), 32'd0);
    applyStimulus(n[7:0]);
    applyStimulus(n[15:8]);
    for (int i = 0; i < wordsToSend.size(); i++) begin
      w = wordsToSend[i];
      for (int k = 0; k < 4; k++) begin
        b = w[8*k +: 8];
        csum = csum ^ b;
        if (maxGap > 0) waitCycles($urandom_range(0, maxGap));
        applyStimulus(b);
      end
    end
    if (badCsum) csum = csum ^ 8'($urandom_range(1, 255));
    applyStimulus(csum);
    waitCycles(2);
    checkWrites(tag, wordsToSend);
    checkOutput({tag, "_done"},  32'(doneCount), badCsum ? 32'd0 : 32'd1);
    checkOutput({tag, "_err"},   32'(err),       badCsum ? 32'd2 : 32'd0);
    checkOutput({tag, "_cpurn"}, 32'(cpu_rst_n), badCsum ? 32'd0 : 32'd1);
    checkOutput({tag, "_busy"},  32'(busy),      32'd0);
  endtask

  task automatic runLenError(input string tag, input logic [15:0] lenField);
    logic [31:0] none[$];
    clearObserved();
    applyStimulus(MAGIC);
    applyStimulus(lenField[7:0]);
    applyStimulus(lenField[15:8]);
    waitCycles(2);
    checkWrites(tag, none);
    checkOutput({tag, "_err"},   32'(err),       32'd1);
    checkOutput({tag, "_cpurn"}, 32'(cpu_rst_n), 32'd0);
    checkOutput({tag, "_busy"},  32'(busy),      32'd0);
    checkOutput({tag, "_done"},  32'(doneCount), 32'd0);
  endtask

  task automatic fillRandomWords(input int n);
    wordsToSend.delete();
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) wordsToSend.push_back({$urandom(), MAGIC} & 32'hFFFFFFFF);
      else wordsToSend.push_back($urandom());
    end
  endtask

  task automatic sendJunk(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == MAGIC) b = 8'h00;
      applyStimulus(b);
    end
  endtask

  // Main sequence: directed scenarios followed by randomized frames
  initial begin
    logic [31:0] none[$];
    int kind;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkResetOutputs("reset");

    wordsToSend = '{32'h00100513, 32'h00200593};
    runFrame("two_words", 1'b0, 0);

    wordsToSend.delete();
    runFrame("empty", 1'b0, 0);

    runLenError("len65", 16'd65);
    runLenError("len_ffff", 16'hFFFF);
    fillRandomWords(1);
    runFrame("recover", 1'b0, 1);

    fillRandomWords(64);
    runFrame("full64", 1'b0, 0);

    fillRandomWords(1);
    runFrame("bad_csum", 1'b1, 0);

    // Stall mid-frame: error appears on the TIMEOUT-th cycle after the last byte
    clearObserved();
    applyStimulus(MAGIC);
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    applyStimulus(8'h13);
    waitCycles(TIMEOUT - 1);
    checkOutput("tmo_before_err",  32'(err),  32'd0);
    checkOutput("tmo_before_busy", 32'(busy), 32'd1);
    waitCycles(1);
    checkOutput("tmo_err",   32'(err),       32'd3);
    checkOutput("tmo_busy",  32'(busy),      32'd0);
    checkOutput("tmo_cpurn", 32'(cpu_rst_n), 32'd0);
    checkWrites("tmo", none);

    wordsToSend.delete();
    runFrame("to_idle", 1'b0, 0);

    clearObserved();
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    applyStimulus(8'h13);
    waitCycles(2);
    checkOutput("junk_busy",  32'(busy),      32'd0);
    checkOutput("junk_cpurn", 32'(cpu_rst_n), 32'd1);
    checkOutput("junk_err",   32'(err),       32'd0);
    checkWrites("junk", none);

    // Reset in the middle of DATA
    applyStimulus(MAGIC);
    applyStimulus(8'h02);
    applyStimulus(8'h00);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    applyStimulus(8'h55);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkResetOutputs("midrst");
    rst = 1'b0;
    clearObserved();
    applyStimulus(8'h66);
    applyStimulus(8'h77);
    waitCycles(2);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkWrites("midrst", none);
    fillRandomWords(2);
    runFrame("after_rst", 1'b0, 2);

    for (int it = 0; it < 24; it++) begin
      sendJunk($urandom_range(0, 3));
      kind = $urandom_range(0, 9);
      if (kind < 6) begin
        fillRandomWords($urandom_range(0, 6));
        runFrame("rnd_ok", 1'b0, 3);
      end else if (kind < 8) begin
        fillRandomWords($urandom_range(0, 4));
        runFrame("rnd_badcs", 1'b1, 3);
      end else begin
        runLenError("rnd_len", 16'($urandom_range(65, 65535)));
      end
    end

    checkOutput("no_done_we_overlap", 32'(overlapCount), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
